cgra_host_ctrl: RTL
===================

CGRA_HOST_CTRL -- requirements
Module: cgra_host_ctrl

Interface
REQ-001 Parameter NUM_TILES, default 4, number of tiles in the array.
REQ-002 Parameter INSTR_W, default 64, per-tile instruction width in bits.
REQ-003 Parameter OUT_W, default 32, per-tile result width in bits.
REQ-004 Parameter CNT_W, default 16, width of the run-length counter.
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  single-cycle request to begin a load-and-run job.
REQ-008 run_len  input  CNT_W  array execution cycles; sampled with start.
REQ-009 abort  input  1  cancels the job in progress.
REQ-010 cfg_valid  input  1  instruction word available.
REQ-011 cfg_data  input  INSTR_W  instruction word.
REQ-012 cfg_ready  output  1  block accepts a cfg word this cycle.
REQ-013 instruction  output  NUM_TILES*INSTR_W  assembled configuration bus to the array.
REQ-014 tile_rst  output  NUM_TILES  per-tile reset to the array, active-high.
REQ-015 final_output  input  NUM_TILES*OUT_W  concatenated tile results from the array.
REQ-016 res_valid  output  1  captured result available.
REQ-017 res_data  output  NUM_TILES*OUT_W  captured result.
REQ-018 res_ready  input  1  consumer accepts the result.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 FSM states: IDLE, LOAD, RUN, DONE; encoded in the shared package.
REQ-021 IDLE: start=1 -> LOAD; latch run_len (0 treated as 1); clear word_cnt; start is ignored in every other state.
REQ-022 LOAD: cfg_ready=1; each cfg_valid&cfg_ready cycle writes cfg_data to instruction[INSTR_W*word_cnt +: INSTR_W] and increments word_cnt.
REQ-023 LOAD: the handshake with word_cnt==NUM_TILES-1 -> RUN; clear cycle_cnt.
REQ-024 tile_rst = all ones in IDLE, LOAD and DONE; all zeros in RUN only.
REQ-025 RUN: cycle_cnt increments each cycle; the cycle with cycle_cnt==latched_len-1 captures final_output into res_data and -> DONE.
REQ-026 Timing: last cfg handshake in cycle L -> tile_rst low for cycles L+1..L+len -> res_valid high from cycle L+len+1.
REQ-027 DONE: res_valid=1; res_data held stable until res_valid&res_ready, then -> IDLE with res_valid=0 next cycle.
REQ-028 instruction retains its last value outside LOAD; it is overwritten only by cfg handshakes.
REQ-029 abort in LOAD or RUN -> IDLE next cycle; no result is produced; tile_rst all ones; partial instruction contents are retained.
REQ-030 abort coinciding with the final cfg handshake or the capture cycle takes priority; the word is still written, the capture is not performed.
REQ-031 abort in IDLE or DONE has no effect.
REQ-032 cfg_valid outside LOAD is ignored; cfg_ready=0 outside LOAD.

Reset
REQ-033 While rst=0 at a clock edge: state=IDLE, instruction=0, res_data=0, res_valid=0, cfg_ready=0, busy=0, tile_rst=all ones, word_cnt=0, cycle_cnt=0.
REQ-034 Reset asserted mid-LOAD, mid-RUN or in DONE discards the job with the same values as REQ-033.

Structure
REQ-035 Shared package cgra_pkg holds the FSM state encoding and the NUM_TILES, INSTR_W and OUT_W defaults.
REQ-036 Single flat module with no sub-module; word_cnt and cycle_cnt are local registers.

Verification
REQ-037 Normal job: start with run_len=3; words 0x11..1, 0x22..2, 0x33..3, 0x44..4 back-to-back; final_output=128'hA5 -> instruction = {0x44..4, 0x33..3, 0x22..2, 0x11..1}; tile_rst=0 for exactly 3 cycles; res_data=128'hA5; res_valid one cycle after the RUN window.
REQ-038 cfg_valid gaps: insert 2 idle cycles between each word -> identical instruction; RUN starts only after the 4th handshake.
REQ-039 Backpressure: res_ready=0 for 5 cycles in DONE while final_output changes -> res_data stays 128'hA5; IDLE follows the cycle after res_ready=1.
REQ-040 Abort mid-RUN (run_len=10, abort at cycle 4) -> IDLE next cycle; tile_rst=all ones; res_valid never asserts; a new start is accepted afterwards.
REQ-041 Edge cases: run_len=0 -> 1-cycle RUN window; rst=0 during LOAD after 2 words -> all outputs at reset values; start during RUN -> ignored.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA host controller.
// Holds the controller FSM state encoding and the default array geometry
// (tile count, per-tile instruction width, per-tile result width).
package cgra_pkg;

    localparam int unsigned NUM_TILES_DEF = 4;
    localparam int unsigned INSTR_W_DEF   = 64;
    localparam int unsigned OUT_W_DEF     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cgra_host_ctrl.sv
// Host-side controller for a small CGRA.
// Runs one load-and-run job at a time: it streams NUM_TILES instruction words
// into the configuration bus, releases the tile resets for run_len cycles,
// captures the array result and holds it until the consumer takes it.
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   start, run_len, abort    job control (run_len sampled with start)
//   cfg_valid/ready/data     instruction word stream in
//   instruction, tile_rst    configuration bus and per-tile resets to the array
//   final_output             concatenated tile results from the array
//   res_valid/ready/data     captured result out
//   busy                     high whenever a job is in progress
module cgra_host_ctrl
    import cgra_pkg::*;
#(
    parameter int unsigned NUM_TILES = NUM_TILES_DEF,
    parameter int unsigned INSTR_W   = INSTR_W_DEF,
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CNT_W-1:0]             run_len,
    input  logic                         abort,
    input  logic                         cfg_valid,
    input  logic [INSTR_W-1:0]           cfg_data,
    output logic                         cfg_ready,
    output logic [NUM_TILES*INSTR_W-1:0] instruction,
    output logic [NUM_TILES-1:0]         tile_rst,
    input  logic [NUM_TILES*OUT_W-1:0]   final_output,
    output logic                         res_valid,
    output logic [NUM_TILES*OUT_W-1:0]   res_data,
    input  logic                         res_ready,
    output logic                         busy
);

    localparam int unsigned WC_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [WC_W-1:0]   word_cnt;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  len_q;
    logic              cfg_hs_c;
    logic              capture_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides the final handshake and the capture
    always_comb begin
        state_nxt = state;
        cfg_hs_c  = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                cfg_hs_c = cfg_valid;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cfg_valid && (word_cnt == WC_W'(NUM_TILES - 1))) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cycle_cnt == (len_q - CNT_W'(1))) begin
                    capture_c = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            tile_rst  <= '1;
        end else begin
            cfg_ready <= (state_nxt == LOAD);
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == DONE);
            tile_rst  <= {NUM_TILES{state_nxt != RUN}};
        end
    end

    // Counters, configuration bus and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_cnt    <= '0;
            cycle_cnt   <= '0;
            len_q       <= CNT_W'(1);
            instruction <= '0;
            res_data    <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                len_q    <= (run_len == '0) ? CNT_W'(1) : run_len;
                word_cnt <= '0;
            end
            if (cfg_hs_c) begin
                for (int t = 0; t < int'(NUM_TILES); t++) begin
                    if (word_cnt == WC_W'(t)) begin
                        instruction[t*INSTR_W +: INSTR_W] <= cfg_data;
                    end
                end
                word_cnt <= word_cnt + WC_W'(1);
            end
            if ((state == LOAD) && (state_nxt == RUN)) begin
                cycle_cnt <= '0;
            end else if (state == RUN) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (capture_c) begin
                res_data <= final_output;
            end
        end
    end

endmodule
